// File: rtl/div_top_if.sv
// EX <-> divider start/done handshake bundle: EX is master, divider is slave.
interface div_top_if #(parameter int XLEN = 32);
  logic            i_start;
  logic [2:0]      i_f3;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic            o_done;
  logic [XLEN-1:0] o_res;

  modport master (output i_start, i_f3, i_rs1, i_rs2, input o_done, o_res);
  modport slave  (input i_start, i_f3, i_rs1, i_rs2, output o_done, o_res);
endinterface

// File: rtl/div_top.sv
// RV32M DIV/DIVU/REM/REMU radix-2 restoring divider, XLEN iterations per op.
// Optional ARVI_DIV_EARLY_EXIT_EN: trivial requests finish at the acceptance edge.
module div_top #(parameter int XLEN = 32) (
  input  logic      i_clk,
  input  logic      i_rst,
  div_top_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t r_state, w_next;

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem, r_quo, r_dvs, r_a, r_res;
  logic [1:0]      r_f3;
  logic            r_na, r_nb, r_dz, r_ovf;

  logic            w_valid, w_sgn, w_na, w_nb, w_dz, w_ovf, w_early, w_last, w_done;
  logic [XLEN-1:0] w_ma, w_mb, w_rem_nx, w_quo_nx, w_it_res, w_e0_res;
  logic [XLEN:0]   w_sh, w_sub;

  function automatic logic [XLEN-1:0] fin(input logic [1:0] f3, input logic na, input logic nb,
                                          input logic dz, input logic ovf,
                                          input logic [XLEN-1:0] q, input logic [XLEN-1:0] r,
                                          input logic [XLEN-1:0] a);
    logic [XLEN-1:0] v;
    if (dz)          v = f3[1] ? a : '1;
    else if (ovf)    v = f3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    else if (f3[1])  v = (!f3[0] && na) ? -r : r;
    else             v = (!f3[0] && (na ^ nb)) ? -q : q;
    return v;
  endfunction

  assign w_valid = bus.i_f3[2];
  assign w_sgn   = ~bus.i_f3[0];
  assign w_na    = w_sgn & bus.i_rs1[XLEN-1];
  assign w_nb    = w_sgn & bus.i_rs2[XLEN-1];
  assign w_ma    = w_na ? -bus.i_rs1 : bus.i_rs1;
  assign w_mb    = w_nb ? -bus.i_rs2 : bus.i_rs2;
  assign w_dz    = (bus.i_rs2 == '0);
  assign w_ovf   = w_sgn && (bus.i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.i_rs2 == '1);
`ifdef ARVI_DIV_EARLY_EXIT_EN
  assign w_early = w_dz | w_ovf | (w_mb > w_ma);
`else
  assign w_early = 1'b0;
`endif
  // Early exit: quotient is 0 and remainder is the dividend magnitude.
  assign w_e0_res = w_valid ? fin(bus.i_f3[1:0], w_na, w_nb, w_dz, w_ovf, '0, w_ma, bus.i_rs1) : '0;

  // Partial remainder after the shift needs one extra bit for the trial subtract.
  assign w_sh     = {r_rem, r_quo[XLEN-1]};
  assign w_sub    = w_sh - {1'b0, r_dvs};
  assign w_rem_nx = w_sub[XLEN] ? w_sh[XLEN-1:0] : w_sub[XLEN-1:0];
  assign w_quo_nx = {r_quo[XLEN-2:0], ~w_sub[XLEN]};
  assign w_last   = (r_cnt == CW'(XLEN-1));
  assign w_it_res = fin(r_f3, r_na, r_nb, r_dz, r_ovf, w_quo_nx, w_rem_nx, r_a);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      IDLE: if (bus.i_start) w_next = (!w_valid || w_early) ? DONE : CALC;
      CALC: if (!bus.i_start) w_next = IDLE;
            else if (w_last)  w_next = DONE;
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0; r_rem <= '0; r_quo <= '0; r_dvs <= '0; r_a <= '0; r_res <= '0;
      r_f3  <= '0; r_na  <= 1'b0; r_nb <= 1'b0; r_dz <= 1'b0; r_ovf <= 1'b0;
    end else if (r_state == IDLE && bus.i_start) begin
      r_f3  <= bus.i_f3[1:0];
      r_na  <= w_na;
      r_nb  <= w_nb;
      r_dz  <= w_dz;
      r_ovf <= w_ovf;
      r_a   <= bus.i_rs1;
      r_quo <= w_ma;
      r_dvs <= w_mb;
      r_rem <= '0;
      r_cnt <= '0;
      if (w_next == DONE) r_res <= w_e0_res;
    end else if (r_state == CALC && bus.i_start) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) r_res <= w_it_res;
    end
  end

  assign bus.o_done = w_done;
  assign bus.o_res  = r_res;
endmodule

// File: tb/tb_div_top.sv
// Directed bench for div_top: vector table plus abort, reset and back-to-back sequences.
module tb_div_top;
  localparam int XLEN = 32;
`ifdef ARVI_DIV_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  localparam int NV = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;

  div_top_if #(.XLEN(XLEN)) bus();
  div_top #(.XLEN(XLEN)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          early;
  } vec_t;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue a request and wait (bounded) for o_done; operands are scrambled once
  // after the acceptance edge to prove they are sampled only on acceptance.
  task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input int scr_at, output logic [31:0] res, output int n);
    bus.i_f3 = f3; bus.i_rs1 = a; bus.i_rs2 = b; bus.i_start = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == scr_at && !bus.o_done) begin
        bus.i_rs1 = ~a;
        bus.i_rs2 = a ^ 32'h5a5a;
      end
    end while (!bus.o_done && n < 200);
    res = bus.o_res;
  endtask

  logic [31:0] res;
  int          lat, elat;

  initial begin
    tbl[0]  = '{3'b101, 32'd100,        32'd7,          32'd14,         1'b0};
    tbl[1]  = '{3'b111, 32'd100,        32'd7,          32'd2,          1'b0};
    tbl[2]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
    tbl[3]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
    tbl[4]  = '{3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0};
    tbl[5]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
    tbl[6]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1'b1};
    tbl[7]  = '{3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
    tbl[8]  = '{3'b110, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1};
    tbl[9]  = '{3'b101, 32'd3,          32'd9,          32'd0,          1'b1};
    tbl[10] = '{3'b111, 32'd3,          32'd9,          32'd3,          1'b1};
    tbl[11] = '{3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
    tbl[12] = '{3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0};
    tbl[13] = '{3'b110, 32'hFFFF_FFFD,  32'd9,          32'hFFFF_FFFD,  1'b1};
    tbl[14] = '{3'b001, 32'd5,          32'd3,          32'd0,          1'b1};
    tbl[15] = '{3'b100, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0};
    tbl[16] = '{3'b101, 32'd0,          32'd5,          32'd0,          1'b1};

    bus.i_start = 1'b0; bus.i_f3 = '0; bus.i_rs1 = '0; bus.i_rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", {31'b0, bus.o_done}, 32'd0);
    chk("rst_res", bus.o_res, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_done", {31'b0, bus.o_done}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      run(tbl[i].f3, tbl[i].a, tbl[i].b, 1, res, lat);
      elat = (!tbl[i].f3[2] || (EE && tbl[i].early)) ? 1 : 33;
      chk($sformatf("v%0d_res", i), res, tbl[i].exp);
      chk($sformatf("v%0d_lat", i), lat, elat);
      bus.i_start = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d_pulse", i), {31'b0, bus.o_done}, 32'd0);
    end

    // Abort: drop start after iteration 10; nothing completes, o_res holds.
    bus.i_f3 = 3'b101; bus.i_rs1 = 32'd1000; bus.i_rs2 = 32'd3; bus.i_start = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    @(posedge clk); #1;
    chk("abort_done", {31'b0, bus.o_done}, 32'd0);
    chk("abort_res", bus.o_res, tbl[NV-1].exp);
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.o_done) chk("abort_late_done", 32'd1, 32'd0);
    end
    chk("abort_res_hold", bus.o_res, tbl[NV-1].exp);
    run(3'b101, 32'd9, 32'd3, 1, res, lat);
    chk("after_abort_res", res, 32'd3);
    chk("after_abort_lat", lat, 33);
    bus.i_start = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a CALC run.
    bus.i_f3 = 3'b111; bus.i_rs1 = 32'd100; bus.i_rs2 = 32'd7; bus.i_start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_done", {31'b0, bus.o_done}, 32'd0);
    chk("midrst_res", bus.o_res, 32'd0);
    rst = 1'b0;
    bus.i_start = 1'b0;
    @(posedge clk); #1;
    chk("midrst_idle", {31'b0, bus.o_done}, 32'd0);

    // Back-to-back with start held: one IDLE cycle, then a fresh 33-cycle op.
    run(3'b101, 32'd20, 32'd4, 1, res, lat);
    chk("b2b0_res", res, 32'd5);
    chk("b2b0_lat", lat, 33);
    run(3'b111, 32'd20, 32'd6, 2, res, lat);
    chk("b2b1_res", res, 32'd2);
    chk("b2b1_lat", lat, 34);
    bus.i_start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_pulse", {31'b0, bus.o_done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
